xor_fault_target: RTL and testbench
===================================

XOR_FAULT_TARGET -- requirements
Module: xor_fault_target

Interface
REQ-001 Parameter WIDTH, 6, number of XOR inputs per channel (2..32).
REQ-002 Parameter CHANNELS, 4, number of independent replicated XOR gates (1..16).
REQ-003 Parameter CNT_W, 16, width of the fault counter and window counter.
REQ-004 sysclk_n  in  1  sole clock; all flops update on the rising edge.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 a  in  WIDTH  shared gate operand bus, driven to all channels.
REQ-007 osc_en  in  1  global oscillation enable for photon-emission location.
REQ-008 osc_mask  in  CHANNELS  per-channel oscillation select.
REQ-009 arm  in  1  single-cycle pulse that starts a monitor window.
REQ-010 abort  in  1  forces an end to monitoring.
REQ-011 win_len  in  CNT_W  monitor window length in cycles; 0 means unbounded.
REQ-012 q  out  CHANNELS  registered XOR output per channel.
REQ-013 busy  out  1  high in ARMED or MONITOR.
REQ-014 done  out  1  high in DONE.
REQ-015 fault_flag  out  1  sticky; set on the first mismatch in the current window.
REQ-016 fault_chan  out  CHANNELS  sticky per-channel mismatch bitmap.
REQ-017 fault_count  out  CNT_W  saturating count of mismatching cycles.

Function
REQ-018 Stage 1: a_r <= a every cycle.
REQ-019 Channel c input 0 SHALL be sysclk_n when osc_en and osc_mask[c] are both high; otherwise it SHALL be a_r[0].
REQ-020 Stage 2: q[c] <= XOR of channel c input 0 and a_r[WIDTH-1:1]; golden g <= XOR reduction of a_r, computed by a separate, unshared gate.
REQ-021 Latency: a change on a at edge k SHALL appear on q at edge k+2.
REQ-022 Mismatch vector m[c] = q[c] XOR g, masked to 0 for any channel oscillating in the cycle that produced q[c].
REQ-023 FSM states: IDLE, ARMED, MONITOR, DONE.
REQ-024 IDLE->ARMED on arm; ARMED clears fault_flag, fault_chan and fault_count and loads the window counter with win_len, then moves to MONITOR after 1 cycle.
REQ-025 MONITOR: each cycle with a nonzero m SHALL increment fault_count by 1, stopping at all-ones, and OR m into fault_chan.
REQ-026 In MONITOR the window counter SHALL decrement each cycle; at count 1 the FSM goes to DONE; with win_len=0 it stays in MONITOR until abort.
REQ-027 Any state goes to DONE on abort; abort in IDLE goes to DONE with the results unchanged.
REQ-028 DONE holds all results; arm in DONE moves to ARMED, which clears the results; otherwise DONE stays.
REQ-029 arm while busy SHALL be ignored; abort and arm in the same cycle: abort wins.
REQ-030 Mismatches outside MONITOR SHALL NOT be counted.

Reset
REQ-031 On rst: state=IDLE; a_r, q, g, fault_chan, fault_count, window counter = 0; fault_flag, busy, done = 0.
REQ-032 rst mid-MONITOR SHALL discard all results in the same edge.

Configuration
REQ-033 Macro FAULT_TIMESTAMP_EN: when defined, it adds output first_fault_cyc [CNT_W].
REQ-034 first_fault_cyc SHALL hold the cycle offset from MONITOR entry (first MONITOR cycle = 0) of the first mismatch; it is cleared in ARMED and by reset.
REQ-035 When FAULT_TIMESTAMP_EN is undefined, the port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-036 Reset, then a=6'b000111 held -> q=4'b1111 two cycles later, fault_count=0, done=0.
REQ-037 arm, win_len=10, no fault -> busy for 11 cycles, then done=1, fault_count=0, fault_flag=0.
REQ-038 Force q[2] stage to invert for 3 cycles inside the window -> fault_count=3, fault_chan=4'b0100, fault_flag=1; with FAULT_TIMESTAMP_EN, first_fault_cyc equals the injection offset.
REQ-039 osc_en=1, osc_mask=4'b0001, a toggling, forced mismatch on channel 0 -> q[0] follows sysclk_n parity, no count; forced mismatch on channel 1 -> counted.
REQ-040 CNT_W=4, persistent fault, win_len=0 -> fault_count saturates at 15; abort -> done=1 with 15 held.
REQ-041 rst asserted mid-MONITOR with fault_count=5 -> next cycle state IDLE and fault_count=0; arm+abort in the same cycle from IDLE -> DONE.

Source files
------------

// File: rtl/xor_fault_target.sv
// xor_fault_target: replicated XOR channels checked against a golden gate.
// Define FAULT_TIMESTAMP_EN to add the first_fault_cyc output.
module xor_fault_target #(
  parameter int WIDTH    = 6,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16
) (
  input  logic                sysclk_n,
  input  logic                rst,
  input  logic [WIDTH-1:0]    a,
  input  logic                osc_en,
  input  logic [CHANNELS-1:0] osc_mask,
  input  logic                arm,
  input  logic                abort,
  input  logic [CNT_W-1:0]    win_len,
  output logic [CHANNELS-1:0] q,
  output logic                busy,
  output logic                done,
  output logic                fault_flag,
  output logic [CHANNELS-1:0] fault_chan,
  output logic [CNT_W-1:0]    fault_count
`ifdef FAULT_TIMESTAMP_EN
  ,
  output logic [CNT_W-1:0]    first_fault_cyc
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_MON,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    a_q;
  logic [CHANNELS-1:0] q_q, q_d;
  logic [CHANNELS-1:0] osc_q, osc_d;
  logic                g_q, g_d;
  logic [CHANNELS-1:0] in0;
  logic [CHANNELS-1:0] m;
  logic [CNT_W-1:0]    win_q, win_d;
  logic                flag_q, flag_d;
  logic [CHANNELS-1:0] chan_q, chan_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`ifdef FAULT_TIMESTAMP_EN
  logic [CNT_W-1:0]    off_q, off_d;
  logic [CNT_W-1:0]    first_q, first_d;
`endif

  // Stage 1: capture the operand bus
  always_ff @(posedge sysclk_n) begin
    if (rst) a_q <= '0;
    else     a_q <= a;
  end

  // Channel gates and an independent golden gate
  always_comb begin
    osc_d = osc_mask & {CHANNELS{osc_en}};
    in0   = '0;
    q_d   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      in0[c] = osc_d[c] ? sysclk_n : a_q[0];
      q_d[c] = ^{in0[c], a_q[WIDTH-1:1]};
    end
    g_d = ^a_q;
  end

  // Stage 2: register channel outputs, golden bit and oscillation tags
  always_ff @(posedge sysclk_n) begin
    if (rst) begin
      q_q   <= '0;
      osc_q <= '0;
      g_q   <= 1'b0;
    end else begin
      q_q   <= q_d;
      osc_q <= osc_d;
      g_q   <= g_d;
    end
  end

  // Oscillating channels cannot be judged against the golden bit
  assign m = (q_q ^ {CHANNELS{g_q}}) & ~osc_q;

  // Monitor FSM next state and result accumulation
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    flag_d  = flag_q;
    chan_d  = chan_q;
    cnt_d   = cnt_q;
`ifdef FAULT_TIMESTAMP_EN
    off_d   = off_q;
    first_d = first_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (arm) state_d = S_ARMED;
      end
      S_ARMED: begin
        flag_d  = 1'b0;
        chan_d  = '0;
        cnt_d   = '0;
        win_d   = win_len;
        state_d = S_MON;
`ifdef FAULT_TIMESTAMP_EN
        off_d   = '0;
        first_d = '0;
`endif
      end
      S_MON: begin
        if (win_q != '0) win_d = win_q - ONE;
        if (win_q == ONE) state_d = S_DONE;
        if (|m) begin
          chan_d = chan_q | m;
          flag_d = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + ONE;
`ifdef FAULT_TIMESTAMP_EN
          if (!flag_q) first_d = off_q;
`endif
        end
`ifdef FAULT_TIMESTAMP_EN
        if (off_q != '1) off_d = off_q + ONE;
`endif
      end
      S_DONE: begin
        if (arm) state_d = S_ARMED;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_DONE;
  end

  // Control and result registers
  always_ff @(posedge sysclk_n) begin
    if (rst) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      flag_q  <= 1'b0;
      chan_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      flag_q  <= flag_d;
      chan_q  <= chan_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FAULT_TIMESTAMP_EN
  // Window offset counter and first-mismatch timestamp
  always_ff @(posedge sysclk_n) begin
    if (rst) begin
      off_q   <= '0;
      first_q <= '0;
    end else begin
      off_q   <= off_d;
      first_q <= first_d;
    end
  end

  assign first_fault_cyc = first_q;
`endif

  assign q           = q_q;
  assign busy        = (state_q == S_ARMED) || (state_q == S_MON);
  assign done        = (state_q == S_DONE);
  assign fault_flag  = flag_q;
  assign fault_chan  = chan_q;
  assign fault_count = cnt_q;

endmodule

// File: tb/tb_xor_fault_target.sv
// tb_xor_fault_target: randomized scoreboard bench for xor_fault_target.
// Define FAULT_TIMESTAMP_EN to also check first_fault_cyc.
module tb_xor_fault_target;

  localparam int W  = 6;
  localparam int C  = 4;
  localparam int CW = 4;
  localparam int MAXC = (1 << CW) - 1;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_MON   = 2;
  localparam int M_DONE  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  a;
  logic          osc_en;
  logic [C-1:0]  osc_mask;
  logic          arm;
  logic          abort;
  logic [CW-1:0] win_len;
  logic [C-1:0]  q;
  logic          busy;
  logic          done;
  logic          fault_flag;
  logic [C-1:0]  fault_chan;
  logic [CW-1:0] fault_count;
`ifdef FAULT_TIMESTAMP_EN
  logic [CW-1:0] first_fault_cyc;
`endif

  xor_fault_target #(
    .WIDTH(W),
    .CHANNELS(C),
    .CNT_W(CW)
  ) dut (
    .sysclk_n(clk),
    .rst(rst),
    .a(a),
    .osc_en(osc_en),
    .osc_mask(osc_mask),
    .arm(arm),
    .abort(abort),
    .win_len(win_len),
    .q(q),
    .busy(busy),
    .done(done),
    .fault_flag(fault_flag),
    .fault_chan(fault_chan),
    .fault_count(fault_count)
`ifdef FAULT_TIMESTAMP_EN
    ,
    .first_fault_cyc(first_fault_cyc)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [C-1:0] q;
    logic         busy;
    logic         done;
    logic         flag;
    logic [C-1:0] chan;
    int           cnt;
    int           first;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int checks = 0;
  int failures = 0;

  // reference model state: values the DUT should show after the next edge
  logic [W-1:0] m_ar;
  logic [C-1:0] m_q;
  logic [C-1:0] m_osc;
  logic         m_g;
  int           m_mode;
  int           m_win;
  logic         m_flag;
  logic [C-1:0] m_chan;
  int           m_cnt;
  int           m_off;
  int           m_first;
  logic [C-1:0] inj_val;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // monitor: compare every registered output just after each edge
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("q", 32'(q), 32'(mon_e.q));
      chk("busy", 32'(busy), 32'(mon_e.busy));
      chk("done", 32'(done), 32'(mon_e.done));
      chk("fault_flag", 32'(fault_flag), 32'(mon_e.flag));
      chk("fault_chan", 32'(fault_chan), 32'(mon_e.chan));
      chk("fault_count", 32'(fault_count), mon_e.cnt);
`ifdef FAULT_TIMESTAMP_EN
      chk("first_fault_cyc", 32'(first_fault_cyc), mon_e.first);
`endif
    end
  end

  function automatic logic par(input logic [W-1:0] v, input int lo);
    int n;
    n = 0;
    for (int i = lo; i < W; i++) n += int'(v[i]);
    return (n % 2) == 1;
  endfunction

  // drive one cycle, advance the model, queue the expectation
  task automatic step(input logic r, input logic [W-1:0] av,
                      input logic oe, input logic [C-1:0] om,
                      input logic ar, input logic ab,
                      input logic [CW-1:0] wl, input logic [C-1:0] inj);
    logic [C-1:0] mism;
    logic [C-1:0] nq;
    logic [C-1:0] nosc;
    int nmode;
    exp_t e;
    rst = r; a = av; osc_en = oe; osc_mask = om;
    arm = ar; abort = ab; win_len = wl;
    if (r) begin
      m_ar = '0; m_q = '0; m_osc = '0; m_g = 1'b0;
      m_mode = M_IDLE; m_win = 0; m_flag = 1'b0;
      m_chan = '0; m_cnt = 0; m_off = 0; m_first = 0;
      release dut.q_d;
    end else begin
      mism = '0;
      for (int c = 0; c < C; c++)
        if (!m_osc[c] && (m_q[c] != m_g)) mism[c] = 1'b1;
      nmode = m_mode;
      case (m_mode)
        M_IDLE: if (ar) nmode = M_ARMED;
        M_ARMED: begin
          m_flag = 1'b0; m_chan = '0; m_cnt = 0;
          m_off = 0; m_first = 0; m_win = int'(wl);
          nmode = M_MON;
        end
        M_MON: begin
          if (mism != '0) begin
            m_cnt = (m_cnt == MAXC) ? MAXC : m_cnt + 1;
            m_chan = m_chan | mism;
            if (!m_flag) m_first = m_off;
            m_flag = 1'b1;
          end
          if (m_off < MAXC) m_off++;
          if (m_win == 1) nmode = M_DONE;
          if (m_win > 0) m_win--;
        end
        default: if (ar) nmode = M_ARMED;
      endcase
      if (ab) nmode = M_DONE;
      m_mode = nmode;
      for (int c = 0; c < C; c++) begin
        nosc[c] = oe & om[c];
        // an oscillating input 0 is sampled high at the rising edge
        nq[c] = nosc[c] ? !par(m_ar, 1) : par(m_ar, 0);
      end
      nq = nq ^ inj;
      inj_val = nq;
      if (inj != '0) force dut.q_d = inj_val;
      else release dut.q_d;
      m_g = par(m_ar, 0);
      m_q = nq;
      m_osc = nosc;
      m_ar = av;
    end
    e.q = m_q;
    e.busy = (m_mode == M_ARMED) || (m_mode == M_MON);
    e.done = (m_mode == M_DONE);
    e.flag = m_flag;
    e.chan = m_chan;
    e.cnt = m_cnt;
    e.first = m_first;
    sb.push_back(e);
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] ra();
    return W'($urandom);
  endfunction

  initial begin
    m_ar = '0; m_q = '0; m_osc = '0; m_g = 1'b0;
    m_mode = M_IDLE; m_win = 0; m_flag = 1'b0;
    m_chan = '0; m_cnt = 0; m_off = 0; m_first = 0;
    inj_val = '0;
    // reset, then a held pattern
    repeat (2) step(1, '0, 0, '0, 0, 0, '0, '0);
    repeat (4) step(0, 6'b000111, 0, '0, 0, 0, '0, '0);
    // fault-free window of 10
    step(0, ra(), 0, '0, 1, 0, 4'd10, '0);
    repeat (13) step(0, ra(), 0, '0, 0, 0, '0, '0);
    // channel 2 inverted for three cycles inside a window
    step(0, ra(), 0, '0, 1, 0, 4'd12, '0);
    repeat (3) step(0, ra(), 0, '0, 0, 0, '0, '0);
    repeat (3) step(0, ra(), 0, '0, 0, 0, '0, 4'b0100);
    repeat (12) step(0, ra(), 0, '0, 0, 0, '0, '0);
    // oscillating channel 0: fault hidden; channel 1: counted
    step(0, ra(), 1, 4'b0001, 1, 0, 4'd12, '0);
    repeat (2) step(0, ra(), 1, 4'b0001, 0, 0, '0, '0);
    repeat (2) step(0, ra(), 1, 4'b0001, 0, 0, '0, 4'b0001);
    repeat (2) step(0, ra(), 1, 4'b0001, 0, 0, '0, 4'b0010);
    repeat (10) step(0, ra(), 1, 4'b0001, 0, 0, '0, '0);
    // unbounded window, persistent fault, saturation, abort
    step(0, ra(), 0, '0, 1, 0, 4'd0, '0);
    repeat (22) step(0, ra(), 0, '0, 0, 0, '0, 4'b0010);
    step(0, ra(), 0, '0, 0, 1, '0, '0);
    repeat (3) step(0, ra(), 0, '0, 0, 0, '0, '0);
    // reset mid-monitor, then arm+abort from idle
    step(0, ra(), 0, '0, 1, 0, 4'd0, '0);
    repeat (6) step(0, ra(), 0, '0, 0, 0, '0, 4'b1000);
    step(1, ra(), 0, '0, 0, 0, '0, '0);
    step(0, ra(), 0, '0, 0, 0, '0, '0);
    step(0, ra(), 0, '0, 1, 1, 4'd5, '0);
    repeat (2) step(0, ra(), 0, '0, 0, 0, '0, '0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [C-1:0] inj;
      inj = ($urandom_range(0, 5) == 0) ? C'($urandom) : '0;
      step($urandom_range(0, 149) == 0, ra(), 1'($urandom),
           C'($urandom), $urandom_range(0, 7) == 0,
           $urandom_range(0, 39) == 0, CW'($urandom), inj);
    end
    repeat (3) step(0, ra(), 0, '0, 0, 0, '0, '0);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain got=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
